// File: rtl/serial_comparator.sv
// ---------------------------------------------------------------------------
// serial_comparator
//
// Multi-cycle magnitude comparator for WIDTH-bit operands. Operands are
// captured on an accepted start and scanned MSB-first, one bit per clock.
// The first differing bit decides the result. The result is published as
// one-hot lt/eq/gt flags, which hold until the next completion.
//
// Parameters:
//   WIDTH      operand width, 2..64 (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only when busy=0
//   is_signed  1 = two's-complement compare, 0 = unsigned (captured with start)
//   a, b       operands (captured with start)
//   busy       high while bits are being scanned
//   done       one-cycle pulse when a result is written
//   lt/eq/gt   one-hot result flags: A<B, A==B, A>B
//
// Configuration macro:
//   SERIAL_CMP_EARLY_EXIT_EN  when defined, the scan also ends on the edge
//                             that finds the first differing bit. Results
//                             are unchanged; only latency shrinks.
// ---------------------------------------------------------------------------
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IW-1:0]    idx_q;
    logic             decided_q;
    logic             less_q;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;

    logic             decided_d;
    logic             less_d;
    logic             bitDiff;
    logic             signBit;
    logic             newLess;
    logic             firstHit;
    logic             scanEnd;

    // Evaluate the bit currently under examination.
    // In a signed compare, the MSB is the sign bit. There, a 1 marks the
    // smaller operand. At every other position, a 1 marks the larger one.
    // Once a decision is recorded, lower bits can no longer change it.
    always_comb begin
        bitDiff   = a_q[idx_q] ^ b_q[idx_q];
        signBit   = signed_q && (idx_q == IW'(WIDTH - 1));
        newLess   = signBit ? a_q[idx_q] : b_q[idx_q];
        firstHit  = bitDiff && !decided_q;
        decided_d = decided_q | bitDiff;
        less_d    = firstHit ? newLess : less_q;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        scanEnd   = (idx_q == '0) || firstHit;
`else
        scanEnd   = (idx_q == '0);
`endif
    end

    // Control FSM with registered handshake outputs and result flags.
    // An accepted start in DONE goes straight back into RUN. This gives
    // back-to-back operation with no idle cycle between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        signed_q  <= is_signed;
                        idx_q     <= IW'(WIDTH - 1);
                        decided_q <= 1'b0;
                        less_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    idx_q     <= idx_q - IW'(1);
                    decided_q <= decided_d;
                    less_q    <= less_d;
                    if (scanEnd) begin
                        lt_q    <= decided_d && less_d;
                        gt_q    <= decided_d && !less_d;
                        eq_q    <= !decided_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_comparator
//
// Self-checking bench for serial_comparator (WIDTH=8). A transaction-level
// reference model tracks the last accepted request. It tracks the start
// edge, the expected latency and the expected result. From these it derives
// busy/done/flags on every cycle. A negedge process compares every cycle.
// Directed cases pin the model with literal values. Randomized traffic
// exercises the rest.
// ---------------------------------------------------------------------------
module tb_serial_comparator;

    localparam int W = 8;
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int       cyc;
    bit       haveOp;
    int       opS;
    int       opLat;
    logic [2:0] opRes;
    logic [2:0] expFlags;
    logic     expBusy;
    logic     expDone;

    serial_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic compare
    function automatic logic [2:0] refResult(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sgn);
        if (x == y) return EQ;
        if (sgn) return ($signed(x) < $signed(y)) ? LT : GT;
        return (x < y) ? LT : GT;
    endfunction

    // Reference latency: WIDTH edges, or up to the first differing bit with early exit
    function automatic int refLatency(input logic [W-1:0] x, input logic [W-1:0] y);
        if (EARLY) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (x[i] != y[i]) return W - i;
            end
        end
        return W;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model, advanced on every clock edge and cleared on reset
    initial begin
        cyc = 0; haveOp = 0; opS = 0; opLat = 0; opRes = 3'b000;
        expFlags = 3'b000; expBusy = 1'b0; expDone = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                haveOp   = 0;
                expFlags = 3'b000;
                expBusy  = 1'b0;
                expDone  = 1'b0;
            end else begin
                cyc++;
                if (haveOp && cyc == opS + opLat) expFlags = opRes;
                if (start && (!haveOp || cyc > opS + opLat)) begin
                    haveOp = 1;
                    opS    = cyc;
                    opLat  = refLatency(a, b);
                    opRes  = refResult(a, b, is_signed);
                end
                expBusy = haveOp && cyc >= opS && cyc < opS + opLat;
                expDone = haveOp && cyc == opS + opLat;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cycle", 32'({busy, done, lt, eq, gt}),
                        32'({expBusy, expDone, expFlags}));
        end
    end

    // One request. Returns the flags and the edge count from E0 to done.
    task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sgn,
                                 input bit scramble, output logic [2:0] flags, output int lat);
        bit seen;
        @(negedge clk); #1;
        a = xa; b = xb; is_signed = sgn; start = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        start = 1'b0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 4 * W) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1;
            #1;
        end
        flags = {lt, eq, gt};
        checkOutput("done_timeout", 32'(seen), 32'(1));
    endtask

    task automatic directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic sgn, input bit scramble,
                            input logic [2:0] wantFlags, input int wantLat);
        logic [2:0] f;
        int l;
        applyStimulus(xa, xb, sgn, scramble, f, l);
        checkOutput({name, "_flags"}, 32'(f), 32'(wantFlags));
        checkOutput({name, "_lat"}, 32'(l), 32'(wantLat));
    endtask

    function automatic logic [W-1:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(8'h80);
            3:       return W'(8'h7F);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int dones;
        int n;
        int firstAt;
        int secondAt;
        logic [2:0] f1;
        logic [2:0] f2;

        rst_n = 1'b0; start = 1'b1; is_signed = 1'b0; a = 8'h05; b = 8'h03;
        #2;
        checkOutput("reset_outputs", 32'({busy, done, lt, eq, gt}), 32'(0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (2 * W + 2) @(negedge clk);

        directed("c1_unsigned", 8'h80, 8'h7F, 1'b0, 1'b0, GT, EARLY ? 1 : 8);
        directed("c2_signed",   8'h80, 8'h7F, 1'b1, 1'b0, LT, EARLY ? 1 : 8);
        directed("c3_eq_u",     8'h5A, 8'h5A, 1'b0, 1'b0, EQ, 8);
        directed("c3_eq_s",     8'h5A, 8'h5A, 1'b1, 1'b0, EQ, 8);
        directed("neg_vs_pos",  8'hFF, 8'h01, 1'b1, 1'b0, LT, EARLY ? 1 : 8);
        directed("neg_lsb",     8'hFE, 8'hFF, 1'b1, 1'b0, LT, 8);
        directed("mid_bit",     8'h10, 8'h00, 1'b0, 1'b0, GT, EARLY ? 4 : 8);
        directed("c6_scramble", 8'h04, 8'h06, 1'b0, 1'b1, LT, EARLY ? 7 : 8);

        // Case 4: start held through RUN, second request taken in the DONE cycle
        @(negedge clk); #1;
        a = 8'h03; b = 8'h01; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        a = 8'h00; b = 8'hFF;
        dones = 0; n = 0; firstAt = 0; secondAt = 0; f1 = '0; f2 = '0;
        while (n < 8 * W) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) begin f1 = {lt, eq, gt}; firstAt = n; end
                else if (dones == 2) begin f2 = {lt, eq, gt}; secondAt = n; end
            end
            #1;
            if (dones >= 1 && busy) start = 1'b0;
        end
        start = 1'b0;
        checkOutput("b2b_first_flags", 32'(f1), 32'(GT));
        checkOutput("b2b_second_flags", 32'(f2), 32'(LT));
        checkOutput("b2b_done_count", 32'(dones), 32'(2));
        checkOutput("b2b_first_lat", 32'(firstAt), 32'(EARLY ? 7 : 8));
        checkOutput("b2b_gap", 32'(secondAt - firstAt), 32'(EARLY ? 2 : 9));

        // Case 5: reset during RUN after a prior lt result
        directed("c5_prior", 8'h01, 8'h02, 1'b0, 1'b0, LT, EARLY ? 7 : 8);
        @(negedge clk); #1;
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset", 32'({busy, done, lt, eq, gt}), 32'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        dones = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("no_done_after_reset", 32'(dones), 32'(0));

        // Randomized traffic, with the occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(negedge clk); #1;
                rst_n = 1'b1;
            end
            start     = ($urandom_range(0, 3) == 0);
            is_signed = 1'($urandom);
            a         = pickVal();
            b         = ($urandom_range(0, 4) == 0) ? a : pickVal();
        end
        @(negedge clk); #1 start = 1'b0;
        repeat (2 * W + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
